reg_share_arb: RTL and testbench
================================

REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the shared register width in bits.
REQ-002 The block SHALL have parameter MAX_HOLD, default 15, giving the maximum HOLD cycles per grant (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the falling edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 4 bits: access request, one bit per requester 0..3.
REQ-006 The block SHALL have port wr, input, 4 bits: write strobe, one bit per requester.
REQ-007 The block SHALL have port wdata, input, 4*WIDTH bits: requester i data on bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port grant, output, 4 bits: one-hot or zero access grant.
REQ-009 The block SHALL have port owner, output, 2 bits: index of the current or last granted requester.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port q, output, WIDTH bits: the shared register contents.
REQ-012 The block SHALL have port timeout, output, 1 bit: one-cycle forced-release pulse.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, GRANT, HOLD and RELEASE.
REQ-014 In IDLE with req nonzero, the block SHALL select the first asserted req at or after round-robin pointer ptr (wrapping 3->0), load owner, and go to GRANT; with req zero it SHALL stay in IDLE.
REQ-015 grant[owner] SHALL be 1 in GRANT and HOLD, and grant SHALL be 0 in IDLE and RELEASE.
REQ-016 Grant latency SHALL be one cycle: a req sampled in IDLE at edge k SHALL give grant high after edge k.
REQ-017 GRANT SHALL last exactly one cycle, SHALL ignore writes, and SHALL then go to HOLD.
REQ-018 In HOLD with req[owner]=1 and wr[owner]=1, q SHALL load wdata slice owner at the next edge.
REQ-019 wr from non-owners SHALL always be ignored.
REQ-020 In HOLD, req[owner]=0 SHALL cause a transition to RELEASE; a wr[owner] sampled on that same edge SHALL be ignored.
REQ-021 RELEASE SHALL last one cycle, set ptr to (owner+1) mod 4, and return to IDLE, giving a minimum two-cycle gap between grants.
REQ-022 Requests from non-owners SHALL never pre-empt a grant, and q SHALL hold its value outside write cycles.
REQ-023 owner SHALL retain its value through RELEASE and IDLE until the next selection.
REQ-024 The hold counter SHALL be an 8-bit counter cleared on entry to HOLD and incremented each HOLD cycle.

Reset
REQ-025 reset=0 SHALL immediately (asynchronously) force state IDLE, grant=0, owner=0, ptr=0, q=0, hold counter=0, timeout=0 and busy=0, including in mid-HOLD.
REQ-026 After reset deasserts, the first selection SHALL start from requester 0.

Configuration
REQ-027 With macro REG_SHARE_ARB_TIMEOUT_EN defined, a HOLD that reaches MAX_HOLD cycles with req[owner] still 1 SHALL go to RELEASE, and timeout SHALL be 1 for that RELEASE cycle only.
REQ-028 Without REG_SHARE_ARB_TIMEOUT_EN, HOLD SHALL last until req[owner] drops, timeout SHALL be tied to 0, and the hold counter SHALL be omitted.

Verification
REQ-029 The bench SHALL check: reset low, then req=4'b0001 at edge 1, then wr[0]=1 with wdata[7:0]=8'hA5 in HOLD -> grant=4'b0001 after edge 1, q=8'hA5 one edge after the write, busy=1.
REQ-030 The bench SHALL check: req=4'b1111 held, each owner dropping req after 3 HOLD cycles -> owner sequence 0,1,2,3,0 with grant never two-hot.
REQ-031 The bench SHALL check: owner 2 in HOLD with wr=4'b0011 and wdata slices 8'h11/8'h22 -> q unchanged.
REQ-032 The bench SHALL check: owner 1 drops req on the same edge as wr[1]=1, wdata=8'h5A -> q unchanged, RELEASE then IDLE, ptr=2.
REQ-033 The bench SHALL check, with the macro defined and MAX_HOLD=4: req[3] held high -> 4 HOLD cycles, a 1-cycle timeout pulse in RELEASE, and re-grant to 3 only after IDLE when no other req is pending.
REQ-034 The bench SHALL check: reset pulsed low mid-HOLD between clock edges with q=8'hFF -> grant=0, q=0 and busy=0 without waiting for a clock edge.

Source files
------------

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter guarding one shared WIDTH-bit register
// among four requesters. All state updates on the falling edge of clk.
//
// Optional feature: define REG_SHARE_ARB_TIMEOUT_EN to force release of a grant
// after MAX_HOLD HOLD cycles (timeout pulses for that RELEASE cycle). Without it,
// a grant lasts until the owner drops req and timeout is tied low.
//
// Ports:
//   clk      clock, falling-edge active
//   reset    asynchronous active-low reset
//   req[3:0] access request per requester
//   wr[3:0]  write strobe per requester (only the owner's is honoured)
//   wdata    requester i data on [i*WIDTH +: WIDTH]
//   grant    one-hot grant in GRANT/HOLD, zero otherwise
//   owner    current or last granted requester
//   busy     high whenever the FSM is not in IDLE
//   q        shared register contents
//   timeout  one-cycle forced-release pulse
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no grant; picks first req at/after ptr
// GRANT   | first grant cycle; writes ignored
// HOLD    | owner may write q; leaves when owner drops req (or times out)
// RELEASE | one-cycle gap; advances ptr past owner
module reg_share_arb #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [3:0]         wr,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         grant,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [WIDTH-1:0]   q,
  output logic               timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("reg_share_arb: MAX_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, GRANT, HOLD, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt, owner_nxt;
  logic [1:0]       pick, idx;
  logic             pick_vld;
  logic [WIDTH-1:0] q_nxt;
  logic             hold_done;
  logic [WIDTH-1:0] slice [4];

  for (genvar i = 0; i < 4; i++) begin : g_slice
    assign slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Scan downward from the furthest offset so the nearest request at or
  // after ptr is the last (winning) assignment.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    idx      = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef REG_SHARE_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_q;

  // Held at zero outside HOLD, so it reads 0 in the first HOLD cycle.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
      timeout_q <= (state == HOLD) && req[owner] && hold_done;
    end
  end

  assign hold_done = (hold_cnt == 8'(MAX_HOLD - 1));
  assign timeout   = timeout_q;
`else
  assign hold_done = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    q_nxt     = q;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: state_nxt = HOLD;
      HOLD: begin
        // Dropping req wins over a same-edge write from the owner.
        if (!req[owner]) begin
          state_nxt = RELEASE;
        end else begin
          if (wr[owner]) q_nxt = slice[owner];
          if (hold_done) state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        ptr_nxt   = owner + 2'd1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      q     <= q_nxt;
    end
  end

  assign grant = (state == GRANT || state == HOLD) ? (4'b0001 << owner) : 4'b0000;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// Bench for reg_share_arb: directed stimulus, a transaction-level model
// checked every cycle, plus hand-computed literal expectations.
module tb_reg_share_arb;
  localparam int WIDTH = 8;
  localparam int MH    = 4;
`ifdef REG_SHARE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk = 1'b1;
  logic               reset;
  logic [3:0]         req, wr;
  logic [4*WIDTH-1:0] wdata;
  logic [3:0]         grant;
  logic [1:0]         owner;
  logic               busy;
  logic [WIDTH-1:0]   q;
  logic               timeout;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // act: a grant is live (GRANT or HOLD); age: 0 on the grant cycle,
  // then the number of the current HOLD cycle.
  typedef struct packed {
    bit               act;
    bit               rel;
    bit               to;
    int unsigned      age;
    logic [1:0]       owner;
    logic [1:0]       ptr;
    logic [WIDTH-1:0] q;
  } model_t;

  model_t m;

  reg_share_arb #(.WIDTH(WIDTH), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wdata(wdata),
    .grant(grant), .owner(owner), .busy(busy), .q(q), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic model_t model_next(model_t c, logic [3:0] r, logic [3:0] w,
                                        logic [4*WIDTH-1:0] d);
    model_t n = c;
    bit found = 1'b0;
    n.to = 1'b0;
    if (c.rel) begin
      n.rel = 1'b0;
    end else if (!c.act) begin
      for (int i = 0; i < 4; i++) begin
        if (!found && r[(c.ptr + i) % 4]) begin
          n.owner = 2'((c.ptr + i) % 4);
          found   = 1'b1;
        end
      end
      if (found) begin
        n.act = 1'b1;
        n.age = 0;
      end
    end else if (c.age == 0) begin
      n.age = 1;
    end else if (!r[c.owner]) begin
      n.act = 1'b0;
      n.rel = 1'b1;
      n.ptr = c.owner + 2'd1;
    end else begin
      if (w[c.owner]) n.q = d[c.owner*WIDTH +: WIDTH];
      if (TO_EN && c.age == MH) begin
        n.act = 1'b0;
        n.rel = 1'b1;
        n.to  = 1'b1;
        n.ptr = c.owner + 2'd1;
      end else begin
        n.age = c.age + 1;
      end
    end
    return n;
  endfunction

  initial begin
    m = '0;
    forever begin
      @(negedge clk or negedge reset);
      if (!reset) m = '0;
      else        m = model_next(m, req, wr, wdata);
    end
  end

  // Outputs change on the falling edge; compare on the rising edge.
  initial forever begin
    @(posedge clk);
    if (check_en) begin
      check("m_grant",   grant,   m.act ? (4'b0001 << m.owner) : 4'b0000);
      check("m_owner",   owner,   m.owner);
      check("m_busy",    busy,    m.act || m.rel);
      check("m_q",       q,       m.q);
      check("m_timeout", timeout, m.to);
      check("onehot",    ($countones(grant) > 1), 0);
    end
  end

  task automatic step(input logic [3:0] r, input logic [3:0] w, input logic [4*WIDTH-1:0] d);
    req   = r;
    wr    = w;
    wdata = d;
    @(posedge clk);
  endtask

  int         exp_own [5] = '{0, 1, 2, 3, 0};
  int         e;
  logic [3:0] others;

  initial begin
    reset = 1'b0;
    req   = '0;
    wr    = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    check("rst_grant", grant, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_q", q, 0);
    check("rst_timeout", timeout, 0);
    reset    = 1'b1;
    check_en = 1'b1;

    // Single requester with a write.
    step(4'b0001, 4'b0000, 32'h0);
    check("t1_grant", grant, 4'b0001);
    check("t1_busy", busy, 1);
    step(4'b0001, 4'b0001, 32'h0000_00A5);
    check("t1_grant_cycle_no_wr", q, 8'h00);
    step(4'b0001, 4'b0001, 32'h0000_00A5);
    check("t1_q", q, 8'hA5);
    check("t1_busy_hold", busy, 1);
    step(4'b0000, 4'b0000, 32'h0);
    check("t1_rel_grant", grant, 0);
    check("t1_rel_busy", busy, 1);
    step(4'b0000, 4'b0000, 32'h0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_owner", owner, 0);

    // Reset between tests: ptr was 1, first selection must restart at 0.
    reset = 1'b0;
    step(4'b0000, 4'b0000, 32'h0);
    reset = 1'b1;

    // Round robin with all requesting.
    for (int k = 0; k < 5; k++) begin
      e      = exp_own[k];
      others = 4'b1111 & ~(4'b0001 << e);
      step(4'hF, 4'h0, 32'h0);
      check("rr_owner", owner, e);
      check("rr_grant", grant, 4'b0001 << e);
      step(4'hF, 4'h0, 32'h0);
      step(4'hF, 4'h0, 32'h0);
      step(4'hF, 4'h0, 32'h0);
      step(others, 4'h0, 32'h0);
      check("rr_release", grant, 0);
      step(4'hF, 4'h0, 32'h0);
      check("rr_idle", busy, 0);
    end

    // Non-owner writes ignored (owner 2).
    step(4'b0100, 4'b0000, 32'h0);
    check("t3_owner", owner, 2);
    step(4'b0100, 4'b0000, 32'h0);
    step(4'b0100, 4'b0100, 32'h0033_0000);
    check("t3_q_set", q, 8'h33);
    step(4'b0100, 4'b0011, 32'h0077_2211);
    check("t3_q_kept", q, 8'h33);
    step(4'b0000, 4'b0000, 32'h0);
    step(4'b0000, 4'b0000, 32'h0);

    // Owner 1 drops req on the same edge as its write.
    step(4'b0010, 4'b0000, 32'h0);
    check("t4_owner", owner, 1);
    step(4'b0010, 4'b0000, 32'h0);
    step(4'b0000, 4'b0010, 32'h0000_5A00);
    check("t4_q_kept", q, 8'h33);
    check("t4_rel_grant", grant, 0);
    check("t4_rel_busy", busy, 1);
    step(4'b0000, 4'b0000, 32'h0);
    check("t4_idle_busy", busy, 0);
    check("t4_owner_kept", owner, 1);
    step(4'b0110, 4'b0000, 32'h0);
    check("t4_ptr2_pick", owner, 2);
    step(4'b0000, 4'b0000, 32'h0);
    step(4'b0000, 4'b0000, 32'h0);
    step(4'b0000, 4'b0000, 32'h0);

`ifdef REG_SHARE_ARB_TIMEOUT_EN
    step(4'b1000, 4'b0000, 32'h0);
    check("to_owner", owner, 3);
    step(4'b1000, 4'b0000, 32'h0);
    check("to_hold1", grant, 4'b1000);
    for (int h = 0; h < 3; h++) begin
      step(4'b1000, 4'b0000, 32'h0);
      check("to_hold", grant, 4'b1000);
    end
    step(4'b1000, 4'b0000, 32'h0);
    check("to_pulse", timeout, 1);
    check("to_rel_grant", grant, 0);
    step(4'b1000, 4'b0000, 32'h0);
    check("to_pulse_end", timeout, 0);
    check("to_idle_grant", grant, 0);
    check("to_idle_busy", busy, 0);
    step(4'b1000, 4'b0000, 32'h0);
    check("to_regrant", grant, 4'b1000);
    step(4'b0000, 4'b0000, 32'h0);
    step(4'b0000, 4'b0000, 32'h0);
    step(4'b0000, 4'b0000, 32'h0);
`else
    step(4'b1000, 4'b0000, 32'h0);
    check("nt_owner", owner, 3);
    step(4'b1000, 4'b0000, 32'h0);
    for (int h = 0; h < 6; h++) begin
      step(4'b1000, 4'b0000, 32'h0);
      check("nt_hold", grant, 4'b1000);
      check("nt_timeout", timeout, 0);
    end
    step(4'b0000, 4'b0000, 32'h0);
    check("nt_rel_timeout", timeout, 0);
    step(4'b0000, 4'b0000, 32'h0);
`endif

    // Asynchronous reset in mid-HOLD.
    step(4'b0100, 4'b0000, 32'h0);
    step(4'b0100, 4'b0000, 32'h0);
    step(4'b0100, 4'b0100, 32'h00FF_0000);
    check("t6_q_ff", q, 8'hFF);
    check("t6_owner_pre", owner, 2);
    #2 reset = 1'b0;
    #1;
    check("t6_grant", grant, 0);
    check("t6_q", q, 0);
    check("t6_busy", busy, 0);
    check("t6_owner", owner, 0);
    check("t6_timeout", timeout, 0);
    @(posedge clk);
    reset = 1'b1;
    step(4'b1010, 4'b0000, 32'h0);
    check("t6_first_pick", owner, 1);
    step(4'b0000, 4'b0000, 32'h0);
    step(4'b0000, 4'b0000, 32'h0);
    step(4'b0000, 4'b0000, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
